// File: rtl/alu_dispatch.sv
// alu_dispatch: hands one command at a time to a shared-bus ALU and returns its results.
// The ALU operands and result share the tri-state buses src0/src1/dst; this block drives the
// operands only while issuing, then releases every bus so the ALU can answer.
// Optional watchdog: define ALU_DISPATCH_TIMEOUT_EN to abort an ISSUE that runs TMO_CYCLES cycles.

`ifndef STATE_SIZE0
`define STATE_SIZE0 1
`endif
`ifndef ALU_BEGIN
`define ALU_BEGIN 2'd1
`endif
`ifndef ALU_RESULTS
`define ALU_RESULTS 2'd2
`endif

module alu_dispatch #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STATE_W    = `STATE_SIZE0 + 1,
    parameter int unsigned IDLE_CODE  = 0,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_oe,
    input  logic               is_bus_busy,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_cmd,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    output logic [31:0]        command,
    output logic [STATE_W-1:0] alu_state,
    inout  wire  [DATA_W-1:0]  src0,
    inout  wire  [DATA_W-1:0]  src1,
    inout  wire  [DATA_W-1:0]  dst,
    input  logic [DATA_W-1:0]  dst_h,
    input  logic               next_state,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_dst,
    output logic [DATA_W-1:0]  rsp_dst_h,
    output logic [DATA_W-1:0]  rsp_src0,
    output logic               rsp_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StCollect, StResp} state_e;

    state_e            state_q, state_d;
    logic [31:0]       cmd_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] rsp_dst_q, rsp_dst_h_q, rsp_src0_q;
    logic              accept, capture;

    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("alu_dispatch: TMO_CYCLES must be at least 1");
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             err_q;
    logic             tmo_fire;
`endif

    assign rsp_valid = (state_q == StResp);
    // rsp_valid is in the term so a pending response always blocks new issue.
    assign req_ready = (state_q == StIdle) && !is_bus_busy && !rsp_valid;
    assign command   = cmd_q;
    assign rsp_dst   = rsp_dst_q;
    assign rsp_dst_h = rsp_dst_h_q;
    assign rsp_src0  = rsp_src0_q;

    // Operands go on the buses only in ISSUE; dst always belongs to the ALU.
    assign src0 = (state_q == StIssue) ? a_q : {DATA_W{1'bz}};
    assign src1 = (state_q == StIssue) ? b_q : {DATA_W{1'bz}};
    assign dst  = {DATA_W{1'bz}};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and single-cycle accept/capture strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Completion wins over a watchdog expiry in the same cycle.
                if (next_state) begin
                    state_d = StCollect;
                end
`ifdef ALU_DISPATCH_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) begin
                    tmo_fire = 1'b1;
                    state_d  = StResp;
                end
`endif
            end
            StCollect: begin
                // Results are only valid on an ALU output phase.
                if (clk_oe) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Phase code shown to the ALU.
    always_comb begin
        alu_state = STATE_W'(IDLE_CODE);
        case (state_q)
            StIssue:   alu_state = STATE_W'(`ALU_BEGIN);
            StCollect: alu_state = STATE_W'(`ALU_RESULTS);
            default:   alu_state = STATE_W'(IDLE_CODE);
        endcase
    end

    // Request latch and response capture; response words hold until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_dst_q   <= '0;
            rsp_dst_h_q <= '0;
            rsp_src0_q  <= '0;
        end else begin
            if (accept) begin
                cmd_q <= req_cmd;
                a_q   <= req_a;
                b_q   <= req_b;
            end
            if (capture) begin
                rsp_dst_q   <= dst;
                rsp_dst_h_q <= dst_h;
                rsp_src0_q  <= src0;
            end
`ifdef ALU_DISPATCH_TIMEOUT_EN
            if (tmo_fire) begin
                rsp_dst_q   <= '0;
                rsp_dst_h_q <= '0;
                rsp_src0_q  <= '0;
            end
`endif
        end
    end

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // Watchdog: counts ISSUE cycles since accept; err marks an aborted operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt_q <= '0;
            end else if (state_q == StIssue) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            if (capture) begin
                err_q <= 1'b0;
            end else if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a behavioural ALU answers on the shared buses, expected responses are
// queued at issue time and a monitor compares them at each response handshake.

module tb_alu_dispatch;

    localparam int DW  = 32;
    localparam int TMO = 16;

    localparam logic [1:0] A_IDLE    = 2'd0;
    localparam logic [1:0] A_BEGIN   = 2'd1;
    localparam logic [1:0] A_RESULTS = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_BAD = 4'hF;

    typedef struct packed {
        logic [DW-1:0] dst;
        logic [DW-1:0] dst_h;
        logic [DW-1:0] src0;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst, clk_oe, is_bus_busy;
    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   req_cmd, command;
    logic [DW-1:0] req_a, req_b, dst_h, rsp_dst, rsp_dst_h, rsp_src0;
    logic [1:0]    alu_state;
    logic          next_state, model_ns, ns_force;
    wire  [DW-1:0] src0, src1, dst;

    logic          drv_dst, drv_src0;
    logic [DW-1:0] dst_val, src0_val;

    rsp_t exp_q[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   issue_count = 0;
    int   ns_delay    = 0;

    always #5 clk = ~clk;

    // Undriven buses read as zero, so a released bus is observable.
    pulldown (src0);
    pulldown (src1);
    pulldown (dst);

    assign dst        = (drv_dst && alu_state == A_RESULTS) ? dst_val : {DW{1'bz}};
    assign src0       = (drv_src0 && alu_state == A_RESULTS) ? src0_val : {DW{1'bz}};
    assign next_state = model_ns | ns_force;

    alu_dispatch #(
        .DATA_W    (DW),
        .IDLE_CODE (0),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_oe     (clk_oe),
        .is_bus_busy(is_bus_busy),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .command    (command),
        .alu_state  (alu_state),
        .src0       (src0),
        .src1       (src1),
        .dst        (dst),
        .dst_h      (dst_h),
        .next_state (next_state),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_dst    (rsp_dst),
        .rsp_dst_h  (rsp_dst_h),
        .rsp_src0   (rsp_src0),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input logic [DW-1:0] d, input logic [DW-1:0] dh,
                              input logic [DW-1:0] s0, input logic err);
        rsp_t r;
        r.dst   = d;
        r.dst_h = dh;
        r.src0  = s0;
        r.err   = err;
        exp_q.push_back(r);
    endtask

    // Offer a request until accepted, then check what the ALU sees in the first ISSUE cycle.
    task automatic send(input logic [31:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int t;
        t         = 0;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_before_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("issue_alu_state", alu_state, A_BEGIN);
        check("issue_command", command, cmd);
        check("issue_src0", src0, a);
        check("issue_src1", src1, b);
        check("issue_dst_released", dst, 0);
        check("issue_req_ready", req_ready, 0);
    endtask

    // Called in the first ISSUE cycle; lat counts cycles since the accept cycle.
    task automatic wait_rsp(input int max, output int lat);
        lat = 1;
        while (!rsp_valid && lat < max) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
    endtask

    // Behavioural ALU: computes from the buses in ISSUE, answers on dst/dst_h (and src0 for MOV).
    initial begin : alu_model
        int              icnt;
        logic [3:0]      op;
        logic [2*DW-1:0] wide;
        icnt     = 0;
        op       = 4'h0;
        wide     = '0;
        model_ns = 1'b0;
        drv_dst  = 1'b0;
        drv_src0 = 1'b0;
        dst_val  = '0;
        src0_val = '0;
        dst_h    = '0;
        forever begin
            @(negedge clk);
            model_ns = 1'b0;
            if (alu_state == A_BEGIN) begin
                if (icnt == 0) issue_count++;
                op = command[31:28];
                case (op)
                    OP_ADD:  wide = {{DW{1'b0}}, src0} + {{DW{1'b0}}, src1};
                    OP_MUL:  wide = {{DW{1'b0}}, src0} * {{DW{1'b0}}, src1};
                    OP_MOV:  wide = {{DW{1'b0}}, src0};
                    default: wide = '0;
                endcase
                dst_val  = wide[DW-1:0];
                dst_h    = wide[2*DW-1:DW];
                src0_val = (op == OP_MOV) ? src1 : '0;
                if (op != OP_BAD && icnt == ns_delay) model_ns = 1'b1;
                icnt++;
            end else begin
                icnt = 0;
            end
            if (alu_state == A_RESULTS) begin
                if (!drv_dst) begin
                    check("collect_src0_released", src0, 0);
                    check("collect_src1_released", src1, 0);
                    check("collect_dst_released", dst, 0);
                end
                drv_dst  = 1'b1;
                drv_src0 = (op == OP_MOV);
            end else begin
                drv_dst  = 1'b0;
                drv_src0 = 1'b0;
            end
        end
    end

    // Monitor: samples just before the edge on which a response handshake completes.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_response", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_dst", rsp_dst, e.dst);
                    check("rsp_dst_h", rsp_dst_h, e.dst_h);
                    check("rsp_src0", rsp_src0, e.src0);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int   lat;
        int   t;
        logic seen;
        rst         = 1'b1;
        clk_oe      = 1'b1;
        is_bus_busy = 1'b0;
        req_valid   = 1'b0;
        req_cmd     = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b1;
        ns_force    = 1'b0;
        repeat (3) @(negedge clk);

        check("reset_alu_state", alu_state, A_IDLE);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_dst", rsp_dst, 0);
        check("reset_rsp_dst_h", rsp_dst_h, 0);
        check("reset_rsp_src0", rsp_src0, 0);
        check("reset_command", command, 0);
        check("reset_src0", src0, 0);
        check("reset_src1", src1, 0);
        check("reset_dst", dst, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD 5+7, ALU answers in the first ISSUE cycle: minimum latency.
        ns_delay = 0;
        expect_rsp(32'd12, 32'd0, 32'd0, 1'b0);
        send({OP_ADD, 28'h00000A5}, 32'd5, 32'd7);
        wait_rsp(20, lat);
        check("min_latency", lat, 3);
        check("resp_alu_state", alu_state, A_IDLE);
        @(negedge clk);
        check("idle_after_add", alu_state, A_IDLE);
        check("idle_command_held", command, {OP_ADD, 28'h00000A5});
        check("idle_src0_released", src0, 0);
        check("idle_src1_released", src1, 0);

        // MUL with clk_oe low: ISSUE still ends on next_state, COLLECT waits for clk_oe.
        clk_oe   = 1'b0;
        ns_delay = 2;
        expect_rsp(32'h0000_0000, 32'h0000_0001, 32'd0, 1'b0);
        send({OP_MUL, 28'h0000000}, 32'h0001_0000, 32'h0001_0000);
        repeat (2) @(negedge clk);
        check("mul_still_issue", alu_state, A_BEGIN);
        @(negedge clk);
        check("mul_collect_without_oe", alu_state, A_RESULTS);
        repeat (3) @(negedge clk);
        check("mul_collect_held", alu_state, A_RESULTS);
        check("mul_no_rsp_without_oe", rsp_valid, 0);
        clk_oe = 1'b1;
        wait_rsp(10, lat);
        @(negedge clk);

        // Back-pressure: response must hold while requests and bus-busy toggle.
        ns_delay  = 0;
        rsp_ready = 1'b0;
        expect_rsp(32'h0000_0123, 32'd0, 32'd0, 1'b0);
        send({OP_ADD, 28'h0000001}, 32'h0000_0100, 32'h0000_0023);
        wait_rsp(20, lat);
        for (int i = 0; i < 10; i++) begin
            req_valid   = i[0];
            is_bus_busy = i[1];
            @(negedge clk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_rsp_dst", rsp_dst, 32'h0000_0123);
            check("stall_req_ready", req_ready, 0);
            check("stall_alu_state", alu_state, A_IDLE);
            check("stall_src0_released", src0, 0);
        end
        req_valid   = 1'b0;
        is_bus_busy = 1'b0;
        rsp_ready   = 1'b1;
        @(negedge clk);
        check("stall_done_idle", rsp_valid, 0);

        // Unknown opcode: the ALU never completes.
        ns_delay = 0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        expect_rsp(32'd0, 32'd0, 32'd0, 1'b1);
        send({OP_BAD, 28'h0000000}, 32'h0000_0011, 32'h0000_0022);
        wait_rsp(100, lat);
        // TMO ISSUE cycles after the accept cycle.
        check("tmo_latency", lat, TMO + 1);
        @(negedge clk);
`else
        send({OP_BAD, 28'h0000000}, 32'h0000_0011, 32'h0000_0022);
        seen = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        check("no_rsp_without_tmo", seen, 0);
        check("bad_still_issue", alu_state, A_BEGIN);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("bad_reset_idle", alu_state, A_IDLE);
`endif

        // MOV: ALU returns a on dst and b on src0.
        expect_rsp(32'hAAAA_0000, 32'd0, 32'h0000_5555, 1'b0);
        send({OP_MOV, 28'h0000000}, 32'hAAAA_0000, 32'h0000_5555);
        wait_rsp(20, lat);
        @(negedge clk);

        // Reset in the second ISSUE cycle, then a late next_state.
        ns_delay = 100;
        send({OP_MOV, 28'h0000007}, 32'h0000_1234, 32'h0000_5678);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        ns_force = 1'b1;
        check("abort_alu_state", alu_state, A_IDLE);
        check("abort_command", command, 0);
        check("abort_src0", src0, 0);
        check("abort_src1", src1, 0);
        check("abort_dst", dst, 0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid | (alu_state != A_IDLE);
        end
        check("late_next_state_ignored", seen, 0);
        ns_force = 1'b0;
        @(negedge clk);

        // Carry into the high word after recovery.
        ns_delay = 0;
        expect_rsp(32'h0000_0001, 32'h0000_0001, 32'd0, 1'b0);
        send({OP_ADD, 28'h0000002}, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_rsp(20, lat);
        check("recovery_latency", lat, 3);
        @(negedge clk);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        check("issue_count", issue_count, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
